// File: rtl/output_seq_monitor_pkg.sv
// Shared types, widths and helpers for the output sequence monitor.
package output_seq_monitor_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned CHAN_W   = 3;
  localparam int unsigned MAX_CHAN = 8;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_DONE = 2'd2
  } mon_state_e;

  // First-failure record captured once per run
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [DATA_W-1:0] expected;
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] cycle;
  } err_rec_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

endpackage

// File: rtl/output_seq_monitor_if.sv
// CPU device-write bus as seen by the monitor (address, data, DI strobe).
interface output_seq_monitor_if;
  import output_seq_monitor_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] bus;
  logic              DI;

  modport master (output addr, output bus, output DI);
  modport slave  (input  addr, input  bus, input  DI);
endinterface

// File: rtl/output_seq_monitor_seq_chan.sv
// One monitored channel: holds the next expected value and whether any output was seen.
module output_seq_monitor_seq_chan
  import output_seq_monitor_pkg::*;
#(
  parameter logic [DATA_W-1:0] START_VAL = 16'h0000,
  parameter logic [DATA_W-1:0] STEP      = 16'h0001
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              clear,
  input  logic              hit,
  input  logic [DATA_W-1:0] bus,
  output logic              mismatch_c,
  output logic [DATA_W-1:0] exp_val,
  output logic              seen
);

  // 4-state compare so X/Z on the bus counts as a mismatch in simulation
  assign mismatch_c = (bus !== exp_val);

  // Expectation advances on every sample, matched or not
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      exp_val <= '0;
      seen    <= 1'b0;
    end else if (clear) begin
      exp_val <= START_VAL;
      seen    <= 1'b0;
    end else if (hit) begin
      exp_val <= exp_val + STEP;
      seen    <= 1'b1;
    end
  end

endmodule

// File: rtl/output_seq_monitor.sv
// Multi-channel output sequence checker: bounded run, totals and first-failure capture.
module output_seq_monitor
  import output_seq_monitor_pkg::*;
#(
  parameter int unsigned       NCHAN      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h0000,
  parameter logic [DATA_W-1:0] START_VAL  = 16'h0000,
  parameter logic [DATA_W-1:0] STEP       = 16'h0001,
  parameter int unsigned       MAX_CYCLES = 3000
) (
  input  logic                 clk,
  input  logic                 reset_bar,
  input  logic                 start,
  output_seq_monitor_if.slave  cpu,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic [DATA_W-1:0]    out_count,
  output logic [DATA_W-1:0]    error_count,
  output logic [CHAN_W-1:0]    err_chan,
  output logic [DATA_W-1:0]    err_expected,
  output logic [DATA_W-1:0]    err_got,
  output logic [DATA_W-1:0]    err_cycle
);

  mon_state_e        state_q, state_d;
  logic [DATA_W-1:0] cycle_q;
  logic [ADDR_W-1:0] off_c;
  logic              in_win_c, sample_c, mism_c, last_c;
  logic [NCHAN-1:0]  hit_c, chan_mism_c, seen;
  logic [DATA_W-1:0] exp_arr [NCHAN];
  logic [DATA_W-1:0] out_d, err_d;
  err_rec_t          rec_c;

  // Window test via offset; valid while BASE_ADDR+NCHAN does not wrap 16 bits
  assign off_c    = cpu.addr - BASE_ADDR;
  assign in_win_c = (off_c < ADDR_W'(NCHAN));
  assign sample_c = (state_q == MON_RUN) && !start && cpu.DI && in_win_c;
  assign last_c   = (cycle_q == DATA_W'(MAX_CYCLES - 1));

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign hit_c[c] = sample_c && (off_c == ADDR_W'(c));

    output_seq_monitor_seq_chan #(
      .START_VAL (START_VAL),
      .STEP      (STEP)
    ) u_chan (
      .clk        (clk),
      .reset_bar  (reset_bar),
      .clear      (start),
      .hit        (hit_c[c]),
      .bus        (cpu.bus),
      .mismatch_c (chan_mism_c[c]),
      .exp_val    (exp_arr[c]),
      .seen       (seen[c])
    );
  end

  // Candidate failure record for the channel sampled this cycle
  always_comb begin
    rec_c       = '0;
    rec_c.got   = cpu.bus;
    rec_c.cycle = cycle_q;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      if (hit_c[c]) begin
        rec_c.chan     = CHAN_W'(c);
        rec_c.expected = exp_arr[c];
      end
    end
    mism_c = |(hit_c & chan_mism_c);
  end

  // Next state and next totals
  always_comb begin
    state_d = state_q;
    out_d   = out_count;
    err_d   = error_count;
    case (state_q)
      MON_IDLE: if (start) state_d = MON_RUN;
      MON_RUN: begin
        if (start)       state_d = MON_RUN;
        else if (last_c) state_d = MON_DONE;
      end
      MON_DONE: if (start) state_d = MON_RUN;
      default:  state_d = MON_IDLE;
    endcase
    if (sample_c)           out_d = sat_inc(out_count);
    if (sample_c && mism_c) err_d = sat_inc(error_count);
  end

  // State, cycle counter, totals and first-failure capture
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q      <= MON_IDLE;
      cycle_q      <= '0;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      out_count    <= '0;
      error_count  <= '0;
      err_chan     <= '0;
      err_expected <= '0;
      err_got      <= '0;
      err_cycle    <= '0;
    end else if (start) begin
      state_q      <= state_d;
      cycle_q      <= '0;
      running      <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      out_count    <= '0;
      error_count  <= '0;
      err_chan     <= '0;
      err_expected <= '0;
      err_got      <= '0;
      err_cycle    <= '0;
    end else if (state_q == MON_RUN) begin
      state_q     <= state_d;
      cycle_q     <= cycle_q + DATA_W'(1);
      out_count   <= out_d;
      error_count <= err_d;
      running     <= (state_d == MON_RUN);
      done        <= (state_d == MON_DONE);
      pass        <= (state_d == MON_DONE) && (err_d == '0) && (&(seen | hit_c));
      if (sample_c && mism_c && (error_count == '0)) begin
        err_chan     <= rec_c.chan;
        err_expected <= rec_c.expected;
        err_got      <= rec_c.got;
        err_cycle    <= rec_c.cycle;
      end
    end
  end

endmodule

// File: tb/tb_output_seq_monitor.sv
// Directed bench for output_seq_monitor: vector table plus hand-written run sequences.
module tb_output_seq_monitor;

  typedef struct {
    int          run;
    logic [15:0] addr;
    logic [15:0] data;
    logic        di;
    logic [15:0] exp_out;
    logic [15:0] exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_bar;
  logic start;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  output_seq_monitor_if bus_if ();

  logic        running0, done0, pass0, running1, done1, pass1;
  logic [15:0] out0, err0, exp0, got0, cyc0, out1, err1, exp1, got1, cyc1;
  logic [2:0]  chan0, chan1;

  output_seq_monitor #(
    .NCHAN(4), .BASE_ADDR(16'h0000), .START_VAL(16'h0000), .STEP(16'h0001), .MAX_CYCLES(3000)
  ) dut0 (
    .clk(clk), .reset_bar(reset_bar), .start(start), .cpu(bus_if.slave),
    .running(running0), .done(done0), .pass(pass0), .out_count(out0), .error_count(err0),
    .err_chan(chan0), .err_expected(exp0), .err_got(got0), .err_cycle(cyc0)
  );

  // Wrap-around configuration, short run
  output_seq_monitor #(
    .NCHAN(4), .BASE_ADDR(16'h0000), .START_VAL(16'hC000), .STEP(16'h4000), .MAX_CYCLES(50)
  ) dut1 (
    .clk(clk), .reset_bar(reset_bar), .start(start), .cpu(bus_if.slave),
    .running(running1), .done(done1), .pass(pass1), .out_count(out1), .error_count(err1),
    .err_chan(chan1), .err_expected(exp1), .err_got(got1), .err_cycle(cyc1)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic add(input int run, input logic [15:0] a, input logic [15:0] d,
                     input logic di, input logic [15:0] eo, input logic [15:0] ee);
    vec_t v;
    v = '{run, a, d, di, eo, ee};
    vecs.push_back(v);
  endtask

  // All stimulus tasks start and end just after a falling edge
  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic di);
    bus_if.addr = a;
    bus_if.bus  = d;
    bus_if.DI   = di;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus_if.DI = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_run(input int id, input bit sel);
    foreach (vecs[i]) begin
      if (vecs[i].run == id) begin
        drive(vecs[i].addr, vecs[i].data, vecs[i].di);
        check($sformatf("run%0d[%0d] out_count", id, i), sel ? out1 : out0, vecs[i].exp_out);
        check($sformatf("run%0d[%0d] error_count", id, i), sel ? err1 : err0, vecs[i].exp_err);
      end
    end
    bus_if.DI = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, input string name);
    int n = 0;
    bus_if.DI = 1'b0;
    while (!(sel ? done1 : done0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " done"}, 16'(sel ? done1 : done0), 16'd1);
  endtask

  initial begin
    reset_bar   = 1'b0;
    start       = 1'b0;
    bus_if.addr = '0;
    bus_if.bus  = '0;
    bus_if.DI   = 1'b0;

    // run 1: three outputs on every channel, all in sequence
    begin
      int n = 0;
      for (int k = 0; k < 3; k++)
        for (int ch = 0; ch < 4; ch++) begin
          n++;
          add(1, 16'(ch), 16'(k), 1'b1, 16'(n), 16'd0);
        end
    end
    // run 2: ch2 emits 0,1,7,3 -- 7 is the only miss since expectation still advances
    add(2, 16'd0, 16'd0, 1'b1, 16'd1, 16'd0);
    add(2, 16'd1, 16'd0, 1'b1, 16'd2, 16'd0);
    add(2, 16'd3, 16'd0, 1'b1, 16'd3, 16'd0);
    add(2, 16'd2, 16'd0, 1'b1, 16'd4, 16'd0);
    add(2, 16'd2, 16'd1, 1'b1, 16'd5, 16'd0);
    add(2, 16'd2, 16'd7, 1'b1, 16'd6, 16'd1);
    add(2, 16'd2, 16'd3, 1'b1, 16'd7, 16'd1);
    // run 7: a miss that a mid-run start must wipe out
    add(7, 16'd0, 16'd5, 1'b1, 16'd1, 16'd1);
    // run 3: only ch0..2 active
    add(3, 16'd0, 16'd0, 1'b1, 16'd1, 16'd0);
    add(3, 16'd1, 16'd0, 1'b1, 16'd2, 16'd0);
    add(3, 16'd2, 16'd0, 1'b1, 16'd3, 16'd0);
    add(3, 16'd2, 16'd1, 1'b1, 16'd4, 16'd0);
    // run 5: out-of-window and strobe-low writes ignored, top of window accepted
    add(5, 16'd4,    16'd0, 1'b1, 16'd0, 16'd0);
    add(5, 16'hFFFF, 16'd0, 1'b1, 16'd0, 16'd0);
    add(5, 16'd3,    16'd0, 1'b0, 16'd0, 16'd0);
    add(5, 16'h0100, 16'd0, 1'b1, 16'd0, 16'd0);
    add(5, 16'd3,    16'd0, 1'b1, 16'd1, 16'd0);
    // run 4 (wrap instance): C000,0000,4000 on ch0, C000 on the others
    add(4, 16'd0, 16'hC000, 1'b1, 16'd1, 16'd0);
    add(4, 16'd0, 16'h0000, 1'b1, 16'd2, 16'd0);
    add(4, 16'd0, 16'h4000, 1'b1, 16'd3, 16'd0);
    add(4, 16'd1, 16'hC000, 1'b1, 16'd4, 16'd0);
    add(4, 16'd2, 16'hC000, 1'b1, 16'd5, 16'd0);
    add(4, 16'd3, 16'hC000, 1'b1, 16'd6, 16'd0);

    repeat (3) @(negedge clk);
    check("reset running", 16'(running0), 16'd0);
    check("reset done", 16'(done0), 16'd0);
    check("reset pass", 16'(pass0), 16'd0);
    check("reset out_count", out0, 16'd0);
    check("reset error_count", err0, 16'd0);
    reset_bar = 1'b1;
    @(negedge clk);

    // Full clean run
    pulse_start();
    check("t1 running", 16'(running0), 16'd1);
    apply_run(1, 1'b0);
    wait_done(1'b0, 3100, "t1");
    check("t1 running after", 16'(running0), 16'd0);
    check("t1 pass", 16'(pass0), 16'd1);
    check("t1 out_count", out0, 16'd12);
    check("t1 error_count", err0, 16'd0);

    // Single mismatch with first-failure record
    pulse_start();
    check("t2 done cleared", 16'(done0), 16'd0);
    apply_run(2, 1'b0);
    wait_done(1'b0, 3100, "t2");
    check("t2 pass", 16'(pass0), 16'd0);
    check("t2 err_chan", 16'(chan0), 16'd2);
    check("t2 err_expected", exp0, 16'd2);
    check("t2 err_got", got0, 16'd7);
    check("t2 err_cycle", cyc0, 16'd5);

    // Restart while running, then a run with an unseen channel
    pulse_start();
    apply_run(7, 1'b0);
    pulse_start();
    check("restart out_count", out0, 16'd0);
    check("restart error_count", err0, 16'd0);
    check("restart err_got", got0, 16'd0);
    check("restart running", 16'(running0), 16'd1);
    apply_run(3, 1'b0);
    wait_done(1'b0, 3100, "t3");
    check("t3 pass", 16'(pass0), 16'd0);
    check("t3 out_count", out0, 16'd4);

    // Window boundaries and the exact last cycle of a run
    pulse_start();
    apply_run(5, 1'b0);
    idle(2994);
    check("t5 done before last", 16'(done0), 16'd0);
    check("t5 running before last", 16'(running0), 16'd1);
    drive(16'd0, 16'd0, 1'b1);
    check("t5 done at last", 16'(done0), 16'd1);
    check("t5 running at last", 16'(running0), 16'd0);
    check("t5 last sample counted", out0, 16'd2);
    check("t5 error_count", err0, 16'd0);
    check("t5 pass", 16'(pass0), 16'd0);
    drive(16'd0, 16'd0, 1'b1);
    check("t5 frozen out_count", out0, 16'd2);
    bus_if.DI = 1'b0;

    // Wrapping sequence on the second instance
    pulse_start();
    apply_run(4, 1'b1);
    wait_done(1'b1, 100, "t4");
    check("t4 pass", 16'(pass1), 16'd1);
    check("t4 out_count", out1, 16'd6);
    check("t4 error_count", err1, 16'd0);

    // Asynchronous reset at cycle 100, then a fresh run
    pulse_start();
    apply_run(1, 1'b0);
    idle(88);
    reset_bar = 1'b0;
    #1;
    check("t6 reset running", 16'(running0), 16'd0);
    check("t6 reset done", 16'(done0), 16'd0);
    check("t6 reset pass", 16'(pass0), 16'd0);
    check("t6 reset out_count", out0, 16'd0);
    check("t6 reset error_count", err0, 16'd0);
    check("t6 reset err_cycle", cyc0, 16'd0);
    @(negedge clk);
    reset_bar = 1'b1;
    @(negedge clk);
    check("t6 idle after reset", 16'(running0), 16'd0);
    pulse_start();
    apply_run(1, 1'b0);
    wait_done(1'b0, 3100, "t6");
    check("t6 pass", 16'(pass0), 16'd1);
    check("t6 out_count", out0, 16'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
